// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add sequencer: slice width,
// FSM state encoding and index width helper.
package wide_add_pkg;

  localparam int SLICE_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width; a single-slice build still carries a 1-bit index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer.sv
// Streams WORDS*20-bit operands through an external 20-bit adder slice, LS slice first.
// Optional subtract mode is enabled by defining WIDE_ADD_SUB_EN (adds port in_sub).
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*SLICE_W-1:0]   in_a,
  input  logic [WORDS*SLICE_W-1:0]   in_b,
  input  logic                       in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                       in_sub,
`endif
  output logic [SLICE_W-1:0]         add_a,
  output logic [SLICE_W-1:0]         add_b,
  output logic                       add_cin,
  input  logic [SLICE_W-1:0]         add_sum,
  input  logic                       add_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*SLICE_W-1:0]   out_sum,
  output logic                       out_cout
);

  localparam int IW      = idx_width(WORDS);
  localparam int TOTAL_W = WORDS * SLICE_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t               state_reg, state_next;
  logic [IW-1:0]        idx_reg;
  logic                 carry_reg;
  logic                 cout_reg;
  logic [TOTAL_W-1:0]   a_reg, b_reg;
  logic [SLICE_W-1:0]   a_slice [WORDS];
  logic [SLICE_W-1:0]   b_slice [WORDS];
  logic [SLICE_W-1:0]   a_cur, b_cur, b_sel;
  logic                 accept;
  logic                 init_carry;

`ifdef WIDE_ADD_SUB_EN
  logic sub_reg;
  assign b_sel      = sub_reg ? ~b_cur : b_cur;
  assign init_carry = in_sub ? 1'b1 : in_cin;
`else
  assign b_sel      = b_cur;
  assign init_carry = in_cin;
`endif

  assign accept   = (state_reg == IDLE) && in_valid;
  assign out_cout = cout_reg;

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
      logic [SLICE_W-1:0] sum_slice_reg;

      assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
      assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
      assign out_sum[gi*SLICE_W +: SLICE_W] = sum_slice_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_slice_reg <= '0;
        end else if (state_reg == RUN && idx_reg == IW'(gi)) begin
          sum_slice_reg <= add_sum;
        end
      end
    end
  endgenerate

  // Explicit compare-mux keeps the select legal for any WORDS, including 1.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_reg == IW'(i)) begin
        a_cur = a_slice[i];
        b_cur = b_slice[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a   = a_cur;
        add_b   = b_sel;
        add_cin = carry_reg;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry ripples between slices only through carry_reg; idx holds at the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_b;
      idx_reg   <= '0;
      carry_reg <= init_carry;
    end else if (state_reg == RUN) begin
      carry_reg <= add_cout;
      if (idx_reg == LAST_IDX) begin
        cout_reg <= add_cout;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

`ifdef WIDE_ADD_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_reg <= 1'b0;
    end else if (accept) begin
      sub_reg <= in_sub;
    end
  end
`endif

endmodule
